// File: rtl/l15_req_arbiter.sv
// Round-robin arbiter sharing the single L1.5 request channel, with per-requester in-flight limits.
// Defining L15_ARB_STATS_EN adds grant_cnt_o / stall_cnt_o statistics counters.
module l15_req_arbiter #(
  parameter int NumReq         = 5,
  parameter int ReqWidth       = 128,
  parameter int PortIdWidth    = 3,
  parameter int MaxOutstanding = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*ReqWidth-1:0] req_data_i,
  output logic [NumReq-1:0]          req_ready_o,
  output logic                       l15_val_o,
  output logic [ReqWidth-1:0]        l15_data_o,
  output logic [PortIdWidth-1:0]     l15_portid_o,
  input  logic                       l15_ack_i,
  input  logic                       rtrn_valid_i,
  input  logic [PortIdWidth-1:0]     rtrn_portid_i,
  output logic                       busy_o
`ifdef L15_ARB_STATS_EN
  ,
  output logic [NumReq*32-1:0]       grant_cnt_o,
  output logic [31:0]                stall_cnt_o
`endif
);

  // state | meaning
  // IDLE  | arbitrate among eligible requesters
  // HOLD  | granted payload presented on L1.5 until ack
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic [0:0]             state;
  logic [PortIdWidth-1:0] ptr;
  logic [CntWidth-1:0]    cnt [NumReq];
  logic [NumReq-1:0]      eligible;
  logic [NumReq-1:0]      sel;
  logic [NumReq-1:0]      inc;
  logic [NumReq-1:0]      dec;
  logic                   zero_rtrn;
  logic                   found;
  logic [PortIdWidth-1:0] grant;
  logic                   accept;

  assign accept = (state == HOLD) && l15_ack_i;

  always_comb begin
    eligible  = '0;
    sel       = '0;
    inc       = '0;
    dec       = '0;
    zero_rtrn = 1'b0;
    busy_o    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] && (cnt[i] < CntWidth'(MaxOutstanding));
      sel[i]      = (l15_portid_o == PortIdWidth'(i));
      inc[i]      = accept && sel[i];
      // Returns on an idle counter are dropped rather than wrapping.
      dec[i]      = rtrn_valid_i && (rtrn_portid_i == PortIdWidth'(i)) && (cnt[i] != '0);
      if (rtrn_valid_i && (rtrn_portid_i == PortIdWidth'(i)) && (cnt[i] == '0))
        zero_rtrn = 1'b1;
      if (cnt[i] != '0)
        busy_o = 1'b1;
    end
  end

  assign req_ready_o = sel & {NumReq{accept}};

  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NumReq; k++) begin
      int idx;
      idx = (int'(ptr) + 1 + k) % NumReq;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        grant = PortIdWidth'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      l15_val_o    <= 1'b0;
      l15_data_o   <= '0;
      l15_portid_o <= '0;
      ptr          <= PortIdWidth'(NumReq - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            l15_data_o   <= req_data_i[int'(grant)*ReqWidth +: ReqWidth];
            l15_portid_o <= grant;
            ptr          <= grant;
            l15_val_o    <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (l15_ack_i) begin
            l15_val_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumReq; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !inc[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

`ifdef L15_ARB_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++)
        if (inc[i])
          grant_cnt_o[i*32 +: 32] <= grant_cnt_o[i*32 +: 32] + 32'd1;
      if ((state == IDLE) && (|req_valid_i) && !(|eligible))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == HOLD) |-> |(req_valid_i & sel));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !zero_rtrn);
`endif

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Scoreboard bench for l15_req_arbiter (MaxOutstanding=2); build with L15_ARB_STATS_EN to cover the stats counters.
module tb_l15_req_arbiter;
  localparam int NR = 5;
  localparam int RW = 128;
  localparam int PW = 3;
  localparam int MO = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR*RW-1:0] req_data_i;
  logic [NR-1:0]    req_ready_o;
  logic             l15_val_o;
  logic [RW-1:0]    l15_data_o;
  logic [PW-1:0]    l15_portid_o;
  logic             l15_ack_i;
  logic             rtrn_valid_i;
  logic [PW-1:0]    rtrn_portid_i;
  logic             busy_o;
`ifdef L15_ARB_STATS_EN
  logic [NR*32-1:0] grant_cnt_o;
  logic [31:0]      stall_cnt_o;
  logic [31:0]      stall0;
`endif

  int total = 0;
  int bad   = 0;
  logic [PW+RW-1:0] exp_q[$];
  logic [PW+RW-1:0] e;
  logic [NR-1:0]    exp_ready;

  l15_req_arbiter #(.NumReq(NR), .ReqWidth(RW), .PortIdWidth(PW), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .l15_val_o(l15_val_o), .l15_data_o(l15_data_o),
    .l15_portid_o(l15_portid_o), .l15_ack_i(l15_ack_i), .rtrn_valid_i(rtrn_valid_i),
    .rtrn_portid_i(rtrn_portid_i), .busy_o(busy_o)
`ifdef L15_ARB_STATS_EN
    , .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input int i, input logic [RW-1:0] d);
    req_data_i[i*RW +: RW] = d;
  endtask

  task automatic expect_grant(input int p, input logic [RW-1:0] d);
    exp_q.push_back({PW'(p), d});
  endtask

  // Every accepted request is matched against the next expected grant.
  always @(negedge clk_i) begin
    if (!rst_i && l15_val_o && l15_ack_i) begin
      if (exp_q.size() == 0) begin
        check("grant_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        exp_ready = {{(NR-1){1'b0}}, 1'b1} << e[RW +: PW];
        check("grant_portid", l15_portid_o, e[RW +: PW]);
        check("grant_data", l15_data_o, e[RW-1:0]);
        check("grant_ready", req_ready_o, exp_ready);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n, last, prev;
    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0;
    l15_ack_i = 1'b0; rtrn_valid_i = 1'b0; rtrn_portid_i = '0;
    #12;
    check("rst_val", l15_val_o, 0);
    check("rst_data", l15_data_o, 0);
    check("rst_portid", l15_portid_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;

    // single request from requester 2, acked at cycle 3
    cyc();
    req_valid_i = 5'b00100; set_data(2, 128'hA5); expect_grant(2, 128'hA5);
    #1;
    check("single_c0_val", l15_val_o, 0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      l15_ack_i = (c == 3);
      #1;
      check("single_val", l15_val_o, 1);
      check("single_portid", l15_portid_o, 2);
      check("single_data", l15_data_o, 128'hA5);
      check("single_ready", req_ready_o, (c == 3) ? 5'b00100 : 5'b00000);
    end
    cyc();
    l15_ack_i = 1'b0; req_valid_i = '0;
    #1;
    check("single_c4_val", l15_val_o, 0);
    check("single_busy", busy_o, 1);
    rtrn_valid_i = 1'b1; rtrn_portid_i = 3'd2;
    cyc();
    rtrn_valid_i = 1'b0;
    #1;
    check("single_drain_busy", busy_o, 0);

    // fairness from a fresh reset: all valid, ack on val, immediate returns
    rst_i = 1'b1; #1; rst_i = 1'b0;
    for (int i = 0; i < NR; i++) set_data(i, 128'h100 + i);
    for (int g = 0; g < 10; g++) expect_grant(g % NR, 128'h100 + (g % NR));
    req_valid_i = 5'h1f;
    n = 0; last = 0; prev = -1;
    for (int c = 0; c < 80 && n < 10; c++) begin
      l15_ack_i = l15_val_o;
      rtrn_valid_i = (prev >= 0);
      rtrn_portid_i = (prev >= 0) ? PW'(prev) : '0;
      prev = -1;
      #1;
      if (l15_val_o && l15_ack_i) begin
        if (n > 0) check("fair_gap", c - last, 2);
        last = c; n++; prev = int'(l15_portid_o);
      end
      cyc();
    end
    check("fair_count", n, 10);
    req_valid_i = '0; l15_ack_i = 1'b0;
    rtrn_valid_i = (prev >= 0); rtrn_portid_i = (prev >= 0) ? PW'(prev) : '0;
    cyc();
    rtrn_valid_i = 1'b0;
    #1;
    check("fair_busy", busy_o, 0);
    check("fair_val", l15_val_o, 0);
`ifdef L15_ARB_STATS_EN
    check("stats_grant0", grant_cnt_o[0*32 +: 32], 2);
    check("stats_grant4", grant_cnt_o[4*32 +: 32], 2);
    check("stats_stall_pre", stall_cnt_o, 0);
    stall0 = stall_cnt_o;
`endif

    // throttle: requester 1 limited to MO grants without returns
    req_valid_i = 5'b00010; set_data(1, 128'h11);
    expect_grant(1, 128'h11); expect_grant(1, 128'h11);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      l15_ack_i = l15_val_o;
      #1;
      if (l15_val_o && l15_ack_i) n++;
      cyc();
    end
    l15_ack_i = 1'b0;
    #1;
    check("thr_count", n, MO);
    check("thr_val", l15_val_o, 0);
    check("thr_busy", busy_o, 1);
`ifdef L15_ARB_STATS_EN
    check("stats_stall_inc", stall_cnt_o > stall0, 1);
`endif
    expect_grant(1, 128'h11);
    rtrn_valid_i = 1'b1; rtrn_portid_i = 3'd1;
    cyc();
    rtrn_valid_i = 1'b0;
    #1;
    check("thr_rtrn_val", l15_val_o, 0);
    cyc();
    l15_ack_i = 1'b1;
    #1;
    check("thr_third_val", l15_val_o, 1);
    check("thr_third_portid", l15_portid_o, 1);
    cyc();
    l15_ack_i = 1'b0; req_valid_i = '0;
    #1;
    check("thr_after_val", l15_val_o, 0);
    rtrn_valid_i = 1'b1; rtrn_portid_i = 3'd1;
    cyc(); cyc();
    rtrn_valid_i = 1'b0;
    #1;
    check("thr_drain_busy", busy_o, 0);

    // simultaneous accept and return on port 0, then an out-of-range return
    req_valid_i = 5'b00001; set_data(0, 128'h55);
    expect_grant(0, 128'h55); expect_grant(0, 128'h55);
    cyc(); l15_ack_i = 1'b1; #1;
    check("sim_first_val", l15_val_o, 1);
    cyc(); l15_ack_i = 1'b0; #1;
    check("sim_cnt1_busy", busy_o, 1);
    cyc(); l15_ack_i = 1'b1; rtrn_valid_i = 1'b1; rtrn_portid_i = 3'd0; #1;
    check("sim_second_val", l15_val_o, 1);
    cyc(); l15_ack_i = 1'b0; req_valid_i = '0; rtrn_portid_i = 3'd7; #1;
    check("sim_after_busy", busy_o, 1);
    check("sim_after_val", l15_val_o, 0);
    cyc(); rtrn_portid_i = 3'd0; #1;
    check("sim_port7_busy", busy_o, 1);
    cyc(); rtrn_valid_i = 1'b0; #1;
    check("sim_drain_busy", busy_o, 0);

    // reset in HOLD while cnt[3]=2
    req_valid_i = 5'b01000; set_data(3, 128'h33);
    expect_grant(3, 128'h33); expect_grant(3, 128'h33);
    cyc(); l15_ack_i = 1'b1;
    cyc(); l15_ack_i = 1'b0;
    cyc(); l15_ack_i = 1'b1;
    cyc(); l15_ack_i = 1'b0; req_valid_i = 5'b01010; set_data(1, 128'h77);
    cyc(); #1;
    check("rst_hold_val", l15_val_o, 1);
    check("rst_hold_portid", l15_portid_o, 1);
    rst_i = 1'b1;
    #1;
    check("rst_mid_val", l15_val_o, 0);
    check("rst_mid_busy", busy_o, 0);
    req_valid_i = 5'b01001; set_data(0, 128'h44);
    expect_grant(0, 128'h44); expect_grant(3, 128'h33);
    #1;
    rst_i = 1'b0;
    cyc(); l15_ack_i = 1'b1; #1;
    check("rst_win_val", l15_val_o, 1);
    check("rst_win_portid", l15_portid_o, 0);
    cyc(); l15_ack_i = 1'b0;
    cyc(); l15_ack_i = 1'b1; #1;
    check("rst_next_portid", l15_portid_o, 3);
    cyc(); l15_ack_i = 1'b0; req_valid_i = '0; rtrn_valid_i = 1'b1; rtrn_portid_i = 3'd0;
    cyc(); rtrn_portid_i = 3'd3;
    cyc(); rtrn_valid_i = 1'b0; #1;
    check("rst_drain_busy", busy_o, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
